// File: rtl/pipe_pkg.sv
// Shared types and width helpers for the elastic pipeline stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    function automatic int entry_width(input int ctrl_w, input int addr_w,
                                       input int num_data, input int data_w);
        return ctrl_w + addr_w + num_data * data_w;
    endfunction

    function automatic logic [1:0] occupancy_of(input stage_state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// Load-enable register holding one packed pipeline entry; clears on synchronous reset.
module pipe_stage_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with a 2-entry skid buffer, flush and bubble control-zeroing.
// Optional stall/flush counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 3,
    parameter int CTRL_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [ADDR_W-1:0]          in_rd,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [ADDR_W-1:0]          out_rd,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [1:0]                 occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt
`endif
);

    localparam int DW      = NUM_DATA * DATA_W;
    localparam int ENTRY_W = entry_width(CTRL_W, ADDR_W, NUM_DATA, DATA_W);

    stage_state_t       state_q, state_d;
    logic               in_fire, out_fire;
    logic               main_load, skid_load, main_sel_skid;
    logic [ENTRY_W-1:0] in_entry, main_d, main_q, skid_q;
    logic [CTRL_W-1:0]  main_ctrl;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign occupancy = occupancy_of(state_q);

    assign in_entry = {in_ctrl, in_rd, in_data};
    assign main_d   = main_sel_skid ? skid_q : in_entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        main_load     = 1'b0;
        skid_load     = 1'b0;
        main_sel_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_load = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_fire && !out_fire) begin
                    skid_load = 1'b1;
                    state_d   = FULL;
                end else if (!in_fire && out_fire) begin
                    state_d = EMPTY;
                end else if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_load     = 1'b1;
                    main_sel_skid = 1'b1;
                    state_d       = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Squashed entries are never written, so out_rd/out_data keep the last real entry.
        if (flush) begin
            state_d   = EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    pipe_stage_slot #(.W(ENTRY_W)) u_main_slot (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    pipe_stage_slot #(.W(ENTRY_W)) u_skid_slot (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_entry),
        .q    (skid_q)
    );

    assign main_ctrl = main_q[ENTRY_W-1 -: CTRL_W];
    assign out_rd    = main_q[DW +: ADDR_W];
    assign out_data  = main_q[DW-1:0];

    // A bubble must never carry write enables downstream.
    genvar gi;
    generate
        for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
            assign out_ctrl[gi] = main_ctrl[gi] & out_valid;
        end
    endgenerate

`ifdef PIPE_STAGE_PERF_EN
    logic             stall_evt, flush_evt;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    assign stall_evt = out_valid & ~out_ready;
    assign flush_evt = flush & ((state_q != EMPTY) | in_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_evt && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_evt && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: accepted entries are queued, a monitor checks outputs.
module tb_pipe_stage_skid;

    localparam int DATA_W   = 32;
    localparam int NUM_DATA = 3;
    localparam int CTRL_W   = 8;
    localparam int ADDR_W   = 5;
    localparam int CNT_W    = 16;
    localparam int DW       = NUM_DATA * DATA_W;
    localparam int EW       = CTRL_W + ADDR_W + DW;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready, flush, out_valid, out_ready;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [ADDR_W-1:0] in_rd, out_rd;
    logic [DW-1:0]     in_data, out_data;
    logic [1:0]        occupancy;

    always #5 clk = ~clk;

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
    logic              in_ready4, out_valid4;
    logic [CTRL_W-1:0] out_ctrl4;
    logic [ADDR_W-1:0] out_rd4;
    logic [DW-1:0]     out_data4;
    logic [1:0]        occupancy4;
    logic [3:0]        stall_cnt4, flush_cnt4;
`endif

    pipe_stage_skid #(
        .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_rd(in_rd), .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_rd(out_rd), .out_data(out_data),
        .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

`ifdef PIPE_STAGE_PERF_EN
    pipe_stage_skid #(
        .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W), .CNT_W(4)
    ) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_ctrl(in_ctrl), .in_rd(in_rd), .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_ctrl(out_ctrl4), .out_rd(out_rd4), .out_data(out_data4),
        .occupancy(occupancy4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );
`endif

    int             checks = 0;
    int             errors = 0;
    int             pops   = 0;
    logic           mon_en = 1'b0;
    logic [EW-1:0]  sb[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mk_data(input logic [ADDR_W-1:0] rd);
        return {32'hC0DE_0000 | 32'(rd), 32'(rd) * 32'd3 + 32'd1, ~32'(rd)};
    endfunction

    task automatic set_inputs(input logic [ADDR_W-1:0] rd, input logic [CTRL_W-1:0] ctrl);
        in_valid = 1'b1;
        in_rd    = rd;
        in_ctrl  = ctrl;
        in_data  = mk_data(rd);
    endtask

    // Holds the entry on the input until the stage accepts it, bounded to 50 cycles.
    task automatic send(input logic [ADDR_W-1:0] rd, input logic [CTRL_W-1:0] ctrl);
        logic ok;
        logic accepted;
        accepted = 1'b0;
        set_inputs(rd, ctrl);
        for (int n = 0; n < 50; n++) begin
            ok = in_ready;
            tick();
            if (ok) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: rd %0d not accepted within 50 cycles, required acceptance", rd);
        end
        in_valid = 1'b0;
        $display("send rd=%0d ctrl=%0h accepted=%0b", rd, ctrl, accepted);
    endtask

    task automatic push_loop();
        forever begin
            @(negedge clk);
            if (!rst && in_valid && in_ready && !flush) begin
                sb.push_back({in_ctrl, in_rd, in_data});
            end
        end
    endtask

    task automatic monitor_loop();
        logic [EW-1:0] exp_e, act_e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
            end else if (mon_en) begin
                if (!out_valid) begin
                    check("bubble_ctrl_zero", 128'(out_ctrl), 128'd0);
                end
                if (out_valid && out_ready) begin
                    act_e = {out_ctrl, out_rd, out_data};
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %0h, required no output", act_e);
                    end else begin
                        exp_e = sb.pop_front();
                        check("sb_entry", 128'(act_e), 128'(exp_e));
                        pops++;
                        $display("out rd=%0d ctrl=%0h", out_rd, out_ctrl);
                    end
                end
                if (flush) begin
                    sb.delete();
                end
            end
        end
    endtask

    int base;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] s0, f0;
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_rd     = '0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        fork
            monitor_loop();
            push_loop();
        join_none

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_ctrl   = CTRL_W'($urandom);
            in_rd     = ADDR_W'($urandom);
            in_data   = {$urandom, $urandom, $urandom};
            flush     = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_ctrl", 128'(out_ctrl), 128'd0);
        check("rst_occupancy", 128'(occupancy), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_rd", 128'(out_rd), 128'd0);
        check("rst_out_data", 128'(out_data), 128'd0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        mon_en    = 1'b1;
        tick();

        // Streaming: one entry per cycle, latency one
        base = pops;
        send(5'd1, 8'h31);
        check("stream_first_valid", 128'(out_valid), 128'd1);
        check("stream_first_rd", 128'(out_rd), 128'd1);
        for (int r = 2; r <= 8; r++) begin
            send(ADDR_W'(r), CTRL_W'(8'h30 + r));
        end
        check("stream_pops_7", 128'(pops - base), 128'd7);
        check("stream_last_rd", 128'(out_rd), 128'd8);
        tick();
        check("stream_pops_8", 128'(pops - base), 128'd8);
        check("stream_drained", 128'(out_valid), 128'd0);

        // Backpressure fills both slots, third entry waits
        base = pops;
        out_ready = 1'b0;
        send(5'd5, 8'h45);
        send(5'd6, 8'h46);
        set_inputs(5'd7, 8'h47);
        check("bp_in_ready", 128'(in_ready), 128'd0);
        check("bp_occupancy", 128'(occupancy), 128'd2);
        check("bp_head_rd", 128'(out_rd), 128'd5);
        tick();
        check("bp_hold_occ", 128'(occupancy), 128'd2);
        out_ready = 1'b1;
        send(5'd7, 8'h47);
        tick();
        tick();
        check("bp_pops", 128'(pops - base), 128'd3);
        check("bp_empty", 128'(occupancy), 128'd0);

        // Flush while FULL with a new entry offered
        base = pops;
        out_ready = 1'b0;
        send(5'd10, 8'h5A);
        send(5'd11, 8'h5B);
        check("fl_full", 128'(occupancy), 128'd2);
        set_inputs(5'd12, 8'h5C);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 128'(out_valid), 128'd0);
        check("fl_out_ctrl", 128'(out_ctrl), 128'd0);
        check("fl_occupancy", 128'(occupancy), 128'd0);
        check("fl_in_ready", 128'(in_ready), 128'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        check("fl_no_output", 128'(pops - base), 128'd0);

        // Flush coinciding with out_fire: head is consumed, incoming entry is dropped
        base = pops;
        send(5'd13, 8'h6D);
        set_inputs(5'd14, 8'h6E);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flfire_occupancy", 128'(occupancy), 128'd0);
        repeat (2) tick();
        check("flfire_pops", 128'(pops - base), 128'd1);

        // Bubble with 8'hFF left in the main slot
        send(5'd20, 8'hFF);
        check("bub_valid_ctrl", 128'(out_ctrl), 128'hFF);
        tick();
        check("bub_out_valid", 128'(out_valid), 128'd0);
        check("bub_out_ctrl", 128'(out_ctrl), 128'd0);
        check("bub_rd_held", 128'(out_rd), 128'd20);

        // Reset mid-transfer discards both slots
        out_ready = 1'b0;
        send(5'd21, 8'h11);
        send(5'd22, 8'h12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_occupancy", 128'(occupancy), 128'd0);
        check("mrst_out_rd", 128'(out_rd), 128'd0);
        check("mrst_in_ready", 128'(in_ready), 128'd1);

`ifdef PIPE_STAGE_PERF_EN
        // Stall and flush counters, plus saturation on a 4-bit instance
        send(5'd3, 8'h03);
        s0 = stall_cnt;
        repeat (5) tick();
        check("perf_stall5", 128'(CNT_W'(stall_cnt - s0)), 128'd5);
        repeat (15) tick();
        check("perf_stall20", 128'(CNT_W'(stall_cnt - s0)), 128'd20);
        check("perf_stall_sat", 128'(stall_cnt4), 128'd15);
        f0 = flush_cnt;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("perf_flush1", 128'(CNT_W'(flush_cnt - f0)), 128'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("perf_flush_idle", 128'(CNT_W'(flush_cnt - f0)), 128'd1);
`endif

        out_ready = 1'b1;
        repeat (3) tick();
        check("sb_drained", 128'(sb.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
